// File: rtl/calc_sequencer.sv
// calc_sequencer: ADD/SUB/MUL sequencer around one shared 8-bit add/subtract unit.
// Define CALC_SEQ_MUL_EN to build the shift-add MUL path; otherwise op 2 is reserved.
module calc_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] result,
  output logic        carry,
  output logic        overflow,
  output logic        err,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
`ifdef CALC_SEQ_MUL_EN
    MUL  = 2'd2,
`endif
    DONE = 2'd3
  } state_t;
  state_t      state_q, state_d;
  logic [7:0]  a_q, a_d, b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] result_q, result_d;
  logic        carry_q, carry_d, overflow_q, overflow_d, err_q, err_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic [7:0]  x, y, yb, sum;
  logic [3:0]  s_lo, s_hi;
  logic        sub, c4, co, ovf;
`ifdef CALC_SEQ_MUL_EN
  logic [15:0] acc_q, acc_d, acc_nxt;
  logic [2:0]  cnt_q, cnt_d;
`endif
  // Shared unit: B-complement stage feeding two 4-bit ripple stages.
  always_comb begin
`ifdef CALC_SEQ_MUL_EN
    x   = state_q == MUL ? acc_q[15:8] : a_q;
    y   = state_q == MUL ? (acc_q[0] ? a_q : 8'h00) : b_q;
    sub = state_q != MUL && op_q == 2'd1;
`else
    x   = a_q;
    y   = b_q;
    sub = op_q == 2'd1;
`endif
    yb = y ^ {8{sub}};
    {c4, s_lo} = {1'b0, x[3:0]} + {1'b0, yb[3:0]} + {4'd0, sub};
    {co, s_hi} = {1'b0, x[7:4]} + {1'b0, yb[7:4]} + {4'd0, c4};
    sum = {s_hi, s_lo};
    ovf = (x[7] == yb[7]) && (sum[7] != x[7]);
  end
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    result_d   = result_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    err_d      = err_q;
    busy_d     = busy_q;
    done_d     = done_q;
`ifdef CALC_SEQ_MUL_EN
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    acc_nxt = {co, sum, acc_q[7:1]};
`endif
    case (state_q)
      IDLE: if (start) begin
        a_d    = a;
        b_d    = b;
        op_d   = op;
        err_d  = 1'b0;
        busy_d = 1'b1;
`ifdef CALC_SEQ_MUL_EN
        state_d = op == 2'd2 ? MUL : EXEC;
        acc_d   = {8'h00, b};
        cnt_d   = 3'd0;
`else
        state_d = EXEC;
`endif
      end
      // op_q[1] set here means reserved (or op 2 when MUL is not built).
      EXEC: begin
        state_d    = DONE;
        done_d     = 1'b1;
        result_d   = op_q[1] ? 16'h0000 : {8'h00, sum};
        carry_d    = !op_q[1] && co;
        overflow_d = !op_q[1] && ovf;
        err_d      = op_q[1];
      end
`ifdef CALC_SEQ_MUL_EN
      MUL: begin
        acc_d = acc_nxt;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d    = DONE;
          done_d     = 1'b1;
          result_d   = acc_nxt;
          carry_d    = 1'b0;
          overflow_d = acc_nxt[15:8] != 8'h00;
          err_d      = 1'b0;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= 8'h00;
      b_q        <= 8'h00;
      op_q       <= 2'd0;
      result_q   <= 16'h0000;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef CALC_SEQ_MUL_EN
      acc_q      <= 16'h0000;
      cnt_q      <= 3'd0;
`endif
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef CALC_SEQ_MUL_EN
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
`endif
    end
  end
  assign result   = result_q;
  assign carry    = carry_q;
  assign overflow = overflow_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign done     = done_q;
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed vector table plus hand sequences for calc_sequencer.
module tb_calc_sequencer;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [7:0]  a = 8'h00, b = 8'h00;
  logic [15:0] result;
  logic        carry, overflow, err, busy, done;
  int tests = 0, fails = 0;
  logic [15:0] prev_res = 16'h0000;

  calc_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .result(result), .carry(carry), .overflow(overflow), .err(err),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  a, b;
    logic [15:0] res;
    logic        c, o, e;
    int          lat;
  } vec_t;

`ifdef CALC_SEQ_MUL_EN
  localparam int MLAT = 8;
`else
  localparam int MLAT = 1;
`endif

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_op(input vec_t v);
    int n;
    @(negedge clk);
    start = 1'b1; op = v.op; a = v.a; b = v.b;
    @(posedge clk); #1;
    start = 1'b0; a = ~v.a; b = ~v.b; op = ~v.op;
    chk("busy_after_start", {15'd0, busy}, 16'd1);
    chk("err_cleared", {15'd0, err}, 16'd0);
    n = 0;
    while (!done && n < 20) begin
      chk("result_held", result, prev_res);
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n[15:0], v.lat[15:0]);
    chk("result", result, v.res);
    chk("carry", {15'd0, carry}, {15'd0, v.c});
    chk("overflow", {15'd0, overflow}, {15'd0, v.o});
    chk("err", {15'd0, err}, {15'd0, v.e});
    chk("busy_in_done", {15'd0, busy}, 16'd1);
    @(posedge clk); #1;
    chk("done_cleared", {15'd0, done}, 16'd0);
    chk("busy_cleared", {15'd0, busy}, 16'd0);
    chk("result_after", result, v.res);
    prev_res = v.res;
  endtask

  vec_t tv[13];
  vec_t mv;
  int dcnt;

  initial begin
    tv[0]  = '{2'd0, 8'h7F, 8'h01, 16'h0080, 1'b0, 1'b1, 1'b0, 1};
    tv[1]  = '{2'd1, 8'h05, 8'h07, 16'h00FE, 1'b0, 1'b0, 1'b0, 1};
    tv[2]  = '{2'd1, 8'h80, 8'h01, 16'h007F, 1'b1, 1'b1, 1'b0, 1};
    tv[3]  = '{2'd0, 8'hFF, 8'h01, 16'h0000, 1'b1, 1'b0, 1'b0, 1};
    tv[4]  = '{2'd0, 8'h80, 8'h80, 16'h0000, 1'b1, 1'b1, 1'b0, 1};
    tv[5]  = '{2'd1, 8'h10, 8'h10, 16'h0000, 1'b1, 1'b0, 1'b0, 1};
    tv[6]  = '{2'd3, 8'h12, 8'h34, 16'h0000, 1'b0, 1'b0, 1'b1, 1};
    tv[7]  = '{2'd0, 8'h01, 8'h01, 16'h0002, 1'b0, 1'b0, 1'b0, 1};
    tv[8]  = '{2'd0, 8'h3C, 8'hC4, 16'h0000, 1'b1, 1'b0, 1'b0, 1};
`ifdef CALC_SEQ_MUL_EN
    tv[9]  = '{2'd2, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b1, 1'b0, 8};
    tv[10] = '{2'd2, 8'h0C, 8'h0A, 16'h0078, 1'b0, 1'b0, 1'b0, 8};
    tv[11] = '{2'd2, 8'h10, 8'h10, 16'h0100, 1'b0, 1'b1, 1'b0, 8};
`else
    tv[9]  = '{2'd2, 8'hFF, 8'hFF, 16'h0000, 1'b0, 1'b0, 1'b1, 1};
    tv[10] = '{2'd0, 8'h0C, 8'h0A, 16'h0016, 1'b0, 1'b0, 1'b0, 1};
    tv[11] = '{2'd2, 8'h10, 8'h10, 16'h0000, 1'b0, 1'b0, 1'b1, 1};
`endif
    tv[12] = '{2'd1, 8'h00, 8'h01, 16'h00FF, 1'b0, 1'b0, 1'b0, 1};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", result, 16'h0000);
    chk("rst_flags", {12'd0, carry, overflow, err, busy}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 13; i++) do_op(tv[i]);

    // Start held high through the whole operation, including the DONE cycle.
    mv = '{2'd2, 8'h0C, 8'h0A, 16'h0078, 1'b0, 1'b0, 1'b0, MLAT};
`ifndef CALC_SEQ_MUL_EN
    mv.res = 16'h0000; mv.e = 1'b1;
`endif
    @(negedge clk);
    start = 1'b1; op = mv.op; a = mv.a; b = mv.b;
    @(posedge clk); #1;
    op = 2'd0; a = 8'h33; b = 8'h44;
    dcnt = 0;
    while (!done && dcnt < 20) begin @(posedge clk); #1; dcnt++; end
    chk("ign_latency", dcnt[15:0], mv.lat[15:0]);
    chk("ign_result", result, mv.res);
    chk("ign_err", {15'd0, err}, {15'd0, mv.e});
    @(posedge clk); #1;
    chk("ign_done_start", {15'd0, busy}, 16'd0);
    chk("ign_result_hold", result, mv.res);
    @(negedge clk); start = 1'b0;
    prev_res = mv.res;
    do_op('{2'd0, 8'h20, 8'h22, 16'h0042, 1'b0, 1'b0, 1'b0, 1});

    // Async reset in the middle of an operation (iteration 4 of MUL when built).
    @(negedge clk);
    start = 1'b1; op = 2'd2; a = 8'hFF; b = 8'hFF;
    @(posedge clk); #1; start = 1'b0;
    if (MLAT > 1) repeat (3) @(posedge clk);
    @(negedge clk); #2; rst = 1'b1; #1;
    chk("arst_result", result, 16'h0000);
    chk("arst_flags", {12'd0, carry, overflow, err, busy}, 16'd0);
    chk("arst_done", {15'd0, done}, 16'd0);
    @(posedge clk); @(negedge clk); rst = 1'b0;
    dcnt = 0;
    repeat (12) begin @(posedge clk); #1; if (done) dcnt++; end
    chk("arst_no_done", dcnt[15:0], 16'd0);
    prev_res = 16'h0000;
    do_op('{2'd0, 8'h01, 8'h01, 16'h0002, 1'b0, 1'b0, 1'b0, 1});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
